mmio_interconnect: RTL and testbench

- Parametrised single-master, N-slave memory-mapped interconnect between the CPU data port and peripherals (data memory, timer, UART, instruction-memory data port, future blocks).
- Replaces hard-wired address decode and combinational read-data muxing with per-slave base/mask windows, a request/acknowledge handshake supporting wait states, a timeout with bus-error response, and a held read-data register.

---
 rtl/mmio_pkg.sv | 13 +
 rtl/mmio_addr_decode.sv | 29 ++
 rtl/mmio_interconnect.sv | 130 +++++++++++++
 tb/tb_mmio_interconnect.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared state encoding, load-type codes and error-counter helpers for the MMIO interconnect.
package mmio_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic [2:0] LT_LB  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LW  = 3'd2;
  localparam logic [2:0] LT_LBU = 3'd4;
  localparam logic [2:0] LT_LHU = 3'd5;
  localparam int ERR_CNT_W = 8;
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return v + ERR_CNT_W'(v != '1);
  endfunction
endpackage

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode: base/mask window match, lowest matching index wins.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = 32,
  parameter int IW = 2,
  parameter logic [N*AW-1:0] BASE = '0,
  parameter logic [N*AW-1:0] MASK = '0
) (
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [N-1:0]  sel,
  output logic [IW-1:0] idx
);
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if ((addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
        hit = 1'b1;
        sel = '0;
        sel[i] = 1'b1;
        idx = IW'(i);
      end
    end
  end
endmodule

// File: rtl/mmio_interconnect.sv
// mmio_interconnect: single-master, N-slave bus with windowed decode, wait-state handshake,
// timeout bus errors and a held read-data register.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             m_req,
  input  logic                             m_we,
  input  logic [ADDR_WIDTH-1:0]            m_addr,
  input  logic [DATA_WIDTH-1:0]            m_wdata,
  input  logic [DATA_WIDTH/8-1:0]          m_be,
  input  logic [2:0]                       m_load_type,
  output logic                             m_busy,
  output logic                             m_done,
  output logic                             m_err,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic [ADDR_WIDTH-1:0]            err_addr,
  output logic [ERR_CNT_W-1:0]             err_count,
  output logic [NUM_SLAVES-1:0]            s_sel,
  output logic                             s_we,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  output logic [DATA_WIDTH/8-1:0]          s_be,
  output logic [2:0]                       s_load_type,
  input  logic [NUM_SLAVES-1:0]            s_ack,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_e state_q, state_d;
  logic hit, we_q, err_q, ack, timeout;
  logic [NUM_SLAVES-1:0] dec_sel, sel_q;
  logic [IW-1:0] dec_idx, idx_q;
  logic [CW-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q, err_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, rd_sel;
  logic [BW-1:0] be_q;
  logic [2:0] lt_q;
  logic [ERR_CNT_W-1:0] err_count_q;
  mmio_addr_decode #(
    .N(NUM_SLAVES), .AW(ADDR_WIDTH), .IW(IW), .BASE(SLAVE_BASE), .MASK(SLAVE_MASK)
  ) u_dec (
    .addr(m_addr), .hit(hit), .sel(dec_sel), .idx(dec_idx)
  );
  assign ack     = s_ack[idx_q];
  assign rd_sel  = s_rdata[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE   ? (m_req ? (hit ? ACCESS : RESP) : IDLE) :
              state_q == ACCESS ? ((ack || timeout) ? RESP : ACCESS) : IDLE;
  end
  // Request fields are cleared on leaving RESP so every s_* output idles at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      lt_q        <= '0;
      sel_q       <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && m_req) begin
        we_q    <= m_we;
        addr_q  <= m_addr;
        wdata_q <= m_wdata;
        be_q    <= m_be;
        lt_q    <= m_load_type;
        sel_q   <= hit ? dec_sel : '0;
        idx_q   <= dec_idx;
        err_q   <= !hit;
        cnt_q   <= '0;
        if (!hit) begin
          err_addr_q  <= m_addr;
          err_count_q <= sat_inc(err_count_q);
        end
      end
      if (state_q == ACCESS) begin
        cnt_q <= cnt_q + CW'(1);
        if (ack || timeout) begin
          sel_q <= '0;
          err_q <= !ack;
          if (!ack) begin
            err_addr_q  <= addr_q;
            err_count_q <= sat_inc(err_count_q);
          end else if (!we_q) begin
            rdata_q <= rd_sel;
          end
        end
      end
      if (state_q == RESP) begin
        we_q    <= 1'b0;
        addr_q  <= '0;
        wdata_q <= '0;
        be_q    <= '0;
        lt_q    <= '0;
        err_q   <= 1'b0;
      end
    end
  end
  assign m_busy      = state_q != IDLE;
  assign m_done      = state_q == RESP;
  assign m_err       = m_done && err_q;
  assign m_rdata     = rdata_q;
  assign err_addr    = err_addr_q;
  assign err_count   = err_count_q;
  assign s_sel       = sel_q;
  assign s_we        = we_q;
  assign s_addr      = addr_q;
  assign s_wdata     = wdata_q;
  assign s_be        = be_q;
  assign s_load_type = lt_q;
endmodule

// File: tb/tb_mmio_interconnect.sv
// tb_mmio_interconnect: randomized self-checking bench with a transaction-level reference model.
module tb_mmio_interconnect;
  localparam int N = 4, AW = 32, DW = 32, TO = 16;
  localparam logic [N*AW-1:0] BASE = {32'h4000_0000, 32'h3000_0000, 32'h1000_0000, 32'h1000_0000};
  localparam logic [N*AW-1:0] MASK = {32'hFFFF_0000, 32'hF000_0000, 32'hFF00_0000, 32'hF000_0000};
  logic clk = 0, rst = 1, m_req = 0, m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [3:0] m_be = '0;
  logic [2:0] m_load_type = '0;
  logic m_busy, m_done, m_err, s_we;
  logic [DW-1:0] m_rdata, s_wdata;
  logic [AW-1:0] err_addr, s_addr;
  logic [7:0] err_count;
  logic [N-1:0] s_sel;
  logic [3:0] s_be;
  logic [2:0] s_load_type;
  logic [N-1:0] s_ack = '0;
  logic [N*DW-1:0] s_rdata = '0;
  int errors = 0, checks = 0;
  logic [31:0] exp_rdata = '0, exp_eaddr = '0;
  int exp_ecnt = 0;
  logic [31:0] win_base [N] = '{32'h1000_0000, 32'h1000_0000, 32'h3000_0000, 32'h4000_0000};
  logic [31:0] win_mask [N] = '{32'hF000_0000, 32'hFF00_0000, 32'hF000_0000, 32'hFFFF_0000};

  mmio_interconnect #(
    .NUM_SLAVES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_load_type(m_load_type), .m_busy(m_busy), .m_done(m_done), .m_err(m_err),
    .m_rdata(m_rdata), .err_addr(err_addr), .err_count(err_count), .s_sel(s_sel), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be), .s_load_type(s_load_type),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & win_mask[i]) == win_base[i]) return i;
    return -1;
  endfunction

  // wait_n: ack after that many wait cycles; negative means the slave never acks.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [2:0] lt, input int wait_n,
                        input logic [3:0] spur, input logic hold, input logic [31:0] rd,
                        input string nm);
    int idx, done_c;
    logic ex_err;
    logic [3:0] exp_sel, exp_s;
    idx = ref_decode(addr);
    ex_err = idx < 0 || wait_n < 0 || wait_n >= TO;
    done_c = idx < 0 ? 1 : ex_err ? TO + 1 : wait_n + 2;
    exp_sel = idx < 0 ? 4'b0 : 4'b1 << idx;
    for (int i = 0; i < N; i++) s_rdata[i*DW +: DW] = $urandom;
    if (idx >= 0) s_rdata[idx*DW +: DW] = rd;
    m_req = 1; m_we = we; m_addr = addr; m_wdata = wd; m_be = be; m_load_type = lt;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clk); #1;
      if (!hold || c >= done_c) m_req = 0;
      s_ack = '0;
      checks++;
      if (m_busy !== (c <= done_c)) begin
        errors++; $display("FAIL %s busy c=%0d got=%b exp=%b", nm, c, m_busy, c <= done_c);
      end
      exp_s = c < done_c ? exp_sel : 4'b0;
      checks++;
      if (s_sel !== exp_s) begin
        errors++; $display("FAIL %s s_sel c=%0d got=%b exp=%b", nm, c, s_sel, exp_s);
      end
      checks++;
      if (m_done !== (c == done_c)) begin
        errors++; $display("FAIL %s m_done c=%0d got=%b exp=%b", nm, c, m_done, c == done_c);
      end
      if (c < done_c && idx >= 0) begin
        checks++;
        if ({s_we, s_addr, s_wdata, s_be, s_load_type} !== {we, addr, wd, be, lt}) begin
          errors++;
          $display("FAIL %s slave_fields c=%0d got=%b/%h/%h/%h/%h exp=%b/%h/%h/%h/%h", nm, c,
                   s_we, s_addr, s_wdata, s_be, s_load_type, we, addr, wd, be, lt);
        end
      end
      if (c == done_c) begin
        if (ex_err) begin
          exp_ecnt = exp_ecnt < 255 ? exp_ecnt + 1 : 255;
          exp_eaddr = addr;
        end else if (!we) exp_rdata = rd;
        checks++;
        if (m_err !== ex_err) begin
          errors++; $display("FAIL %s m_err got=%b exp=%b", nm, m_err, ex_err);
        end
        checks++;
        if (m_rdata !== exp_rdata) begin
          errors++; $display("FAIL %s m_rdata got=%h exp=%h", nm, m_rdata, exp_rdata);
        end
      end
      if (c == done_c + 1) begin
        checks++;
        if (err_count !== 8'(exp_ecnt) || err_addr !== exp_eaddr) begin
          errors++;
          $display("FAIL %s err_state got=%0d/%h exp=%0d/%h", nm, err_count, err_addr, exp_ecnt, exp_eaddr);
        end
        checks++;
        if (m_rdata !== exp_rdata || s_addr !== '0 || s_we !== 1'b0) begin
          errors++;
          $display("FAIL %s idle_state got=%h/%h/%b exp=%h/0/0", nm, m_rdata, s_addr, s_we, exp_rdata);
        end
      end
      s_ack = spur & ~exp_sel;
      if (idx >= 0 && wait_n >= 0 && c < done_c && c == wait_n + 1) s_ack = s_ack | exp_sel;
    end
    s_ack = '0;
  endtask

  function automatic logic [31:0] pick_addr(input int k);
    case (k)
      0: return 32'h1000_0000 | ($urandom & 32'h0FFF_FFFF);
      1: return 32'h3000_0000 | ($urandom & 32'h0FFF_FFFF);
      2: return 32'h4000_0000 | ($urandom & 32'h0000_FFFF);
      3: return 32'hF000_0000 | ($urandom & 32'h0FFF_FFFF);
      default: return 32'h4001_0000 | ($urandom & 32'h0000_FFFF);
    endcase
  endfunction

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({m_busy, m_done, m_err, m_rdata, err_addr, err_count, s_sel, s_we, s_addr, s_wdata, s_be, s_load_type} !== '0) begin
      errors++;
      $display("FAIL reset outputs got=%b%b%b %h %h %0d %b %b %h %h %h %h exp=all-zero", m_busy, m_done, m_err,
               m_rdata, err_addr, err_count, s_sel, s_we, s_addr, s_wdata, s_be, s_load_type);
    end
    rst = 0;
  endtask

  task automatic test_zero_wait_read;
    do_txn(0, 32'h1000_0004, 32'h0, 4'h0, 3'd2, 0, 4'b0, 0, 32'hDEAD_BEEF, "zero_wait_read");
  endtask

  task automatic test_wait_write;
    do_txn(1, 32'h3000_0100, 32'hCAFE_F00D, 4'b0110, 3'd0, 3, 4'b0, 0, 32'h1234_5678, "wait_write");
  endtask

  task automatic test_miss;
    do_txn(0, 32'hF000_0000, 32'h0, 4'h0, 3'd2, 0, 4'b1111, 0, 32'h0, "decode_miss");
  endtask

  task automatic test_timeout;
    do_txn(0, 32'h4000_0040, 32'h0, 4'h0, 3'd2, -1, 4'b0, 0, 32'h0, "timeout");
    do_txn(0, 32'h3000_0008, 32'h0, 4'h0, 3'd2, 1, 4'b0, 0, 32'h0BAD_F00D, "after_timeout");
    do_txn(0, 32'h1000_0008, 32'h0, 4'h0, 3'd2, TO - 1, 4'b0, 0, 32'h5555_AAAA, "ack_last_cycle");
  endtask

  task automatic test_overlap;
    do_txn(0, 32'h1012_3456, 32'h0, 4'h0, 3'd4, 2, 4'b0010, 1, 32'h0F0F_0F0F, "overlap");
  endtask

  task automatic test_random;
    for (int t = 0; t < 40; t++) begin
      int k, w;
      k = $urandom_range(0, 4);
      w = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) w = -1;
      do_txn($urandom_range(0, 1) == 1, pick_addr(k), $urandom, 4'($urandom), 3'($urandom),
             w, 4'($urandom), $urandom_range(0, 1) == 1, $urandom, "random");
    end
  endtask

  task automatic test_rst_mid;
    int dn;
    m_req = 1; m_we = 0; m_addr = 32'h3000_0010;
    @(posedge clk); #1;
    m_req = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (s_sel !== 4'b0100) begin
      errors++; $display("FAIL rst_mid pre_sel got=%b exp=0100", s_sel);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_rdata = '0; exp_ecnt = 0; exp_eaddr = '0;
    checks++;
    if ({s_sel, m_busy, m_done, m_rdata, err_count, err_addr, s_addr} !== '0) begin
      errors++;
      $display("FAIL rst_mid outputs got=%b %b %b %h %0d %h %h exp=all-zero", s_sel, m_busy, m_done,
               m_rdata, err_count, err_addr, s_addr);
    end
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      dn += int'(m_done);
    end
    checks++;
    if (dn !== 0) begin
      errors++; $display("FAIL rst_mid stray_done got=%0d exp=0", dn);
    end
  endtask

  task automatic test_saturate;
    for (int t = 0; t < 300; t++)
      do_txn(0, pick_addr(3 + (t % 2)), 32'h0, 4'h0, 3'd0, 0, 4'b0, 0, 32'h0, "saturate");
    checks++;
    if (err_count !== 8'd255) begin
      errors++; $display("FAIL saturate final got=%0d exp=255", err_count);
    end
    do_txn(0, 32'h4000_0004, 32'h0, 4'h0, 3'd2, 0, 4'b0, 0, 32'h7777_1111, "back_to_back");
    do_txn(1, 32'h1000_0000, 32'h89AB_CDEF, 4'hF, 3'd2, 0, 4'b0, 0, 32'h0, "back_to_back");
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_miss();
    test_timeout();
    test_overlap();
    test_random();
    test_rst_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
